snake_body_control: RTL and testbench
=====================================

SNAKE_BODY_CONTROL -- requirements
Module: Snake_Body_Control

Interface
REQ-001 Parameter MOVE_PERIOD, 250000, clk cycles between moves.
REQ-002 Parameter MAX_LEN, 16, maximum segment count.
REQ-003 Parameter X_MAX, 38 / Y_MAX, 28, last playable column / row; 0 and X_MAX+1 / Y_MAX+1 are walls.
REQ-004 clk  input  1  the block's single clock.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-006 key_up, key_down, key_left, key_right  input  1 each  debounced single-cycle direction pulses.
REQ-007 addLength  input  1  grow level from the food stage, held high for a whole check period.
REQ-008 headX, headY  output  6 each  registered head coordinates, consumed by the food stage.
REQ-009 length  output  5  current segment count.
REQ-010 game_over  output  1  high while in OVER.
REQ-011 pixX, pixY  input  6 each  display query cell.
REQ-012 is_body, is_head  output  1 each  registered query results.

Function
REQ-013 State machine IDLE, RUN, OVER shall be used.
- IDLE -> RUN: on any accepted direction key.
- RUN -> OVER: on collision.
- OVER held until rst.
REQ-014 Body shall be stored as MAX_LEN X/Y pairs seg[0..MAX_LEN-1], with seg[0] as the head; entries at index >= length are don't-care.
REQ-015 Move counter shall count 0..MOVE_PERIOD-1 only in RUN, wrap to 0, and assert tick for one cycle when equal to MOVE_PERIOD-1; the counter is held at 0 outside RUN.
REQ-016 Direction handling:
- dir is the direction of the last executed move.
- next_dir is updated on a key pulse unless that key is the opposite of dir; an opposite key is ignored.
- Simultaneous keys resolve by priority up > down > left > right before the reversal check.
- In IDLE a rejected key does not start the game.
REQ-017 Coordinate deltas: up Y-1, down Y+1, left X-1, right X+1; the new head is computed in 6-bit arithmetic.
REQ-018 Grow request:
- grow_pending is set on the rising edge of addLength (addLength=1 while its 1-cycle delayed copy=0).
- grow_pending is cleared on the tick that consumes it.
- A rising edge coincident with a tick is consumed by that tick.
REQ-019 Wall collision: on tick, if new X is 0 or > X_MAX, or new Y is 0 or > Y_MAX, the block enters OVER; segments and length are unchanged.
REQ-020 Self collision: on tick, a new head equal to any seg[i] for i in 0..length-2 (not growing) or 0..length-1 (growing) enters OVER with no move, since a vacating tail is legal.
REQ-021 Legal move on tick:
- seg[i] <= seg[i-1] for i=1..MAX_LEN-1.
- seg[0] <= new head.
- dir <= next_dir.
- length increments by 1 if grow_pending and length < MAX_LEN.
- At length == MAX_LEN the grow request is discarded and cleared.
REQ-022 headX/headY shall equal seg[0] registered and update in the cycle after the tick.
REQ-023 is_head shall equal (pix == seg[0]), and is_body shall equal (pix == seg[i] for any i in 1..length-1), both valid one cycle after pixX/pixY are presented; both are 0 in OVER.
REQ-024 Keys and addLength shall be ignored in OVER.

Reset
REQ-025 When rst is high at a clk edge, the block shall enter the following state, overriding any tick or key in the same cycle:
- state IDLE; move counter 0.
- seg[0]=(20,15), seg[1]=(19,15), seg[2]=(18,15); length=3.
- dir=next_dir=right; grow_pending=0; addLength delay=0.
- headX=20, headY=15; game_over=0; is_body=is_head=0.
REQ-026 rst asserted mid-RUN or in OVER shall restore the REQ-025 state with no residual move.

Verification (MOVE_PERIOD=4)
REQ-027 Reset, then key_right pulse -> RUN; head moves (21,15), (22,15), ... every 4 cycles; length stays 3.
REQ-028 From reset, key_left pulse -> rejected, state stays IDLE, head stays (20,15); key_up -> RUN, next head (20,14).
REQ-029 In RUN, addLength held high 10 cycles -> exactly one growth; length 3 -> 4 on the next tick; the tail does not advance that tick.
REQ-030 Head at (38,y) moving right -> tick sets game_over=1; head stays (38,y); later keys and addLength are ignored.
REQ-031 Length 5 with a down, left, up key sequence -> head re-enters its own body -> OVER; moving into the cell the tail vacates that tick (no growth) -> no OVER.
REQ-032 With length at MAX_LEN, apply addLength -> length stays 16 and the grow request is cleared; assert rst mid-run -> REQ-025 values next cycle.

Source files
------------

// File: rtl/snake_body_control.sv
// snake_body_control: snake body state, move timing, growth, collision and display query.
module snake_body_control #(
   parameter int MOVE_PERIOD = 250000,
   parameter int MAX_LEN     = 16,
   parameter int X_MAX       = 38,
   parameter int Y_MAX       = 28
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       addLength,
   input  logic [5:0] pixX,
   input  logic [5:0] pixY,
   output logic [5:0] headX,
   output logic [5:0] headY,
   output logic [4:0] length,
   output logic       game_over,
   output logic       is_body,
   output logic       is_head
);
   localparam int CW = MOVE_PERIOD > 1 ? $clog2(MOVE_PERIOD) : 1;
   typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
   typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
   state_t        state_q;
   dir_t          dir_q, next_dir_q, key_dir;
   logic [CW-1:0] cnt_q;
   logic [5:0]    seg_x_q [MAX_LEN];
   logic [5:0]    seg_y_q [MAX_LEN];
   logic [4:0]    length_q;
   logic          grow_q, add_dly_q, is_head_q, is_body_q;
   logic          tick, key_ok, rise, grow_ok, wall, hit, body_hit;
   logic [5:0]    nx, ny;
   assign headX     = seg_x_q[0];
   assign headY     = seg_y_q[0];
   assign length    = length_q;
   assign game_over = state_q == OVER;
   assign is_head   = is_head_q;
   assign is_body   = is_body_q;
   always_comb begin
      key_dir  = key_up ? UP : key_down ? DOWN : key_left ? LEFT : RIGHT;
      // UP/DOWN and LEFT/RIGHT differ only in bit 0, so flipping it gives the reverse
      key_ok   = (key_up | key_down | key_left | key_right) && state_q != OVER &&
                 key_dir != dir_t'(dir_q ^ 2'b01);
      tick     = state_q == RUN && cnt_q == CW'(MOVE_PERIOD - 1);
      rise     = addLength && !add_dly_q && state_q != OVER;
      grow_ok  = (grow_q || rise) && length_q < 5'(MAX_LEN);
      nx       = seg_x_q[0] + (next_dir_q == RIGHT ? 6'd1 : next_dir_q == LEFT ? 6'h3f : 6'd0);
      ny       = seg_y_q[0] + (next_dir_q == DOWN ? 6'd1 : next_dir_q == UP ? 6'h3f : 6'd0);
      wall     = nx == 6'd0 || nx > 6'(X_MAX) || ny == 6'd0 || ny > 6'(Y_MAX);
      hit      = 1'b0;
      body_hit = 1'b0;
      // the tail cell counts as occupied only when it will not vacate this move
      for (int i = 0; i < MAX_LEN; i++) begin
         if (i < int'(length_q) - (grow_ok ? 0 : 1) && seg_x_q[i] == nx && seg_y_q[i] == ny)
            hit = 1'b1;
         if (i > 0 && i < int'(length_q) && seg_x_q[i] == pixX && seg_y_q[i] == pixY)
            body_hit = 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dir_q      <= RIGHT;
         next_dir_q <= RIGHT;
         grow_q     <= 1'b0;
         add_dly_q  <= 1'b0;
         is_head_q  <= 1'b0;
         is_body_q  <= 1'b0;
         length_q   <= 5'd3;
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_q[i] <= '0;
            seg_y_q[i] <= '0;
         end
         seg_x_q[0] <= 6'd20;
         seg_x_q[1] <= 6'd19;
         seg_x_q[2] <= 6'd18;
         seg_y_q[0] <= 6'd15;
         seg_y_q[1] <= 6'd15;
         seg_y_q[2] <= 6'd15;
      end else begin
         cnt_q     <= (state_q == RUN && !tick) ? cnt_q + CW'(1) : '0;
         add_dly_q <= addLength;
         grow_q    <= tick ? 1'b0 : grow_q | rise;
         is_head_q <= state_q != OVER && pixX == seg_x_q[0] && pixY == seg_y_q[0];
         is_body_q <= state_q != OVER && body_hit;
         if (key_ok) next_dir_q <= key_dir;
         if (state_q == IDLE && key_ok) state_q <= RUN;
         if (tick) begin
            if (wall || hit) state_q <= OVER;
            else begin
               for (int i = 1; i < MAX_LEN; i++) begin
                  seg_x_q[i] <= seg_x_q[i-1];
                  seg_y_q[i] <= seg_y_q[i-1];
               end
               seg_x_q[0] <= nx;
               seg_y_q[0] <= ny;
               dir_q      <= next_dir_q;
               if (grow_ok) length_q <= length_q + 5'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_snake_body_control.sv
// tb_snake_body_control: directed checks of movement, growth, collisions and reset.
module tb_snake_body_control;
   logic       clk = 1'b0, rst = 1'b1;
   logic       key_up = 0, key_down = 0, key_left = 0, key_right = 0, addLength = 0;
   logic [5:0] pixX = 0, pixY = 0, headX, headY;
   logic [4:0] length;
   logic       game_over, is_body, is_head;
   int         checks = 0, errors = 0;
   localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;
   snake_body_control #(.MOVE_PERIOD(4)) dut (
      .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down), .key_left(key_left),
      .key_right(key_right), .addLength(addLength), .pixX(pixX), .pixY(pixY),
      .headX(headX), .headY(headY), .length(length), .game_over(game_over),
      .is_body(is_body), .is_head(is_head)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic do_reset();
      rst = 1'b1;
      step(1);
      rst = 1'b0;
   endtask
   task automatic press(input int k);
      key_up = k == UP; key_down = k == DOWN; key_left = k == LEFT; key_right = k == RIGHT;
      step(1);
      {key_up, key_down, key_left, key_right} = '0;
   endtask
   task automatic grow_move();
      addLength = 1'b1;
      step(1);
      addLength = 1'b0;
      step(3);
   endtask
   initial begin
      step(1);
      do_reset();
      chk("rst_headX", headX, 20);
      chk("rst_headY", headY, 15);
      chk("rst_length", length, 3);
      chk("rst_game_over", game_over, 0);
      chk("rst_is_head", is_head, 0);
      chk("rst_is_body", is_body, 0);
      pixX = 19; pixY = 15; step(1);
      chk("q_body_seg1", is_body, 1);
      chk("q_head_seg1", is_head, 0);
      pixX = 20; step(1);
      chk("q_head_seg0", is_head, 1);
      chk("q_body_seg0", is_body, 0);
      pixX = 17; step(1);
      chk("q_body_beyond_len", is_body, 0);
      // basic run to the right
      press(RIGHT); step(3);
      chk("run_no_early_move", headX, 20);
      step(1);
      chk("run_move1_x", headX, 21);
      chk("run_move1_y", headY, 15);
      step(4);
      chk("run_move2_x", headX, 22);
      chk("run_len", length, 3);
      // reversal rejected in IDLE, then up accepted
      do_reset();
      press(LEFT); step(5);
      chk("rej_headX", headX, 20);
      chk("rej_game_over", game_over, 0);
      press(UP); step(3);
      chk("up_not_yet", headY, 15);
      step(1);
      chk("up_headY", headY, 14);
      chk("up_headX", headX, 20);
      // held addLength grows exactly once and the tail stays put that tick
      do_reset();
      press(RIGHT);
      addLength = 1; pixX = 18; pixY = 15;
      step(4);
      chk("grow_len4", length, 4);
      chk("grow_headX", headX, 21);
      step(1);
      chk("grow_tail_kept", is_body, 1);
      step(3);
      chk("grow_move2_x", headX, 22);
      chk("grow_once_len", length, 4);
      step(2); addLength = 0; step(2);
      chk("grow_move3_x", headX, 23);
      chk("grow_still4", length, 4);
      step(1);
      chk("grow_tail_left", is_body, 0);
      // wall collision on the right edge
      do_reset();
      press(RIGHT); step(4 * 18);
      chk("wall_at_edge_x", headX, 38);
      chk("wall_not_over", game_over, 0);
      step(4);
      chk("wall_over", game_over, 1);
      chk("wall_head_x", headX, 38);
      chk("wall_head_y", headY, 15);
      press(UP); addLength = 1; pixX = 38; pixY = 15; step(10); addLength = 0;
      chk("over_held", game_over, 1);
      chk("over_head_y", headY, 15);
      chk("over_len", length, 3);
      chk("over_is_head", is_head, 0);
      // self collision at length 5
      do_reset();
      press(RIGHT); grow_move(); grow_move();
      chk("self_len5", length, 5);
      chk("self_head_x", headX, 22);
      press(DOWN); step(3);
      chk("self_down_y", headY, 16);
      press(LEFT); step(3);
      chk("self_left_x", headX, 21);
      press(UP); step(3);
      chk("self_over", game_over, 1);
      chk("self_head_kept_x", headX, 21);
      chk("self_head_kept_y", headY, 16);
      chk("self_len_kept", length, 5);
      // moving into the vacating tail is legal
      do_reset();
      press(RIGHT); grow_move();
      press(DOWN); step(3);
      press(LEFT); step(3);
      press(UP); step(3);
      chk("tail_no_over", game_over, 0);
      chk("tail_head_x", headX, 20);
      chk("tail_head_y", headY, 15);
      // saturate at MAX_LEN, then reset mid-run
      do_reset();
      press(RIGHT);
      repeat (13) grow_move();
      chk("max_len16", length, 16);
      chk("max_head_x", headX, 33);
      grow_move();
      chk("max_len_sat", length, 16);
      chk("max_head_x2", headX, 34);
      step(4);
      chk("max_len_after", length, 16);
      chk("max_not_over", game_over, 0);
      pixX = 35; pixY = 15;
      step(2);
      rst = 1'b1; pixX = 20; step(1); rst = 1'b0;
      chk("mid_rst_x", headX, 20);
      chk("mid_rst_y", headY, 15);
      chk("mid_rst_len", length, 3);
      chk("mid_rst_is_head", is_head, 0);
      step(8);
      chk("mid_rst_no_move", headX, 20);
      chk("mid_rst_idle", game_over, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
